pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the single-cycle core: holds the instruction address, and each cycle either increments it, holds it, or adds the signed branch offset produced by the branch-target lookup. Sits directly downstream of the target LUT and upstream of instruction memory. It owns the run/halt control of the core: it starts from a loaded address, stops on a halt instruction, reports completion, and counts retired instructions.

## Interface
- D, 12, PC and branch-offset width; all PC arithmetic is modulo 2^D.
- CW, 16, width of the retired-instruction counter.

- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin execution at start_addr; honoured only in IDLE or DONE.
- start_addr  input  D  first instruction address.
- stall  input  1  freeze the PC and counter this cycle.
- branch_en  input  1  take the branch this cycle.
- target  input  D  two's-complement PC offset from the target LUT.
- halt  input  1  the current instruction is a halt.
- prog_ctr  output  D  current instruction address; registered.
- running  output  1  high in RUN.
- done  output  1  high in DONE; registered.
- retired  output  CW  instructions retired since the last accepted start; saturating.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: IDLE, prog_ctr=0, done=0, running=0, retired=0.

- **IDLE**
  - start=1: prog_ctr<=start_addr, retired<=0, go to RUN.
  - All other inputs are ignored.

- **RUN**, applying the first matching rule:
  1. halt=1: prog_ctr holds, retired+1, go to DONE.
  2. stall=1: prog_ctr and retired hold, stay in RUN.
  3. branch_en=1: prog_ctr<=(prog_ctr+target) mod 2^D, retired+1.
  4. Otherwise: prog_ctr<=(prog_ctr+1) mod 2^D, retired+1.
  - start is ignored in RUN.
  - A halt asserted together with stall still halts, because halt has priority.

- **DONE**
  - done=1; prog_ctr and retired hold.
  - start=1: same action as from IDLE, and done clears.

- Arithmetic and width rules:
  - target is added as a D-bit value with the carry discarded. An offset of all ones means -1, and an offset of 0 re-executes the same address (a spin loop).
  - retired saturates at 2^CW-1 and does not wrap.
  - running is decoded from the state register. done is a registered flag, equivalent to state==DONE.

## Timing
- All outputs are registered. A decision made on the inputs sampled at edge k is visible on the outputs immediately after edge k.
- prog_ctr is valid combinationally for the instruction-memory read in the same cycle. target and branch_en are expected to be stable before the next edge.
- A start accepted at edge k puts start_addr on prog_ctr after edge k. The instruction at start_addr executes in the cycle between edges k and k+1.
- A halt sampled at edge k raises done after edge k. prog_ctr keeps the halt instruction's address.
- Reset_n low asynchronously forces the reset values, even mid-RUN. Release is synchronised by the caller.
- Wrap-around:
  - prog_ctr=2^D-1 with no branch goes to 0.
  - A branch whose sum overflows or underflows wraps silently, with no error flag.

## Structure
- Shared package pc_pkg holds:
  - PC_W=12, the default width of D.
  - typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_t.
  - The function pc_add(pc, off), which returns a D-bit modulo sum.
- One sub-module, sat_counter, is natural for retired. Its ports are Clk, Reset_n, clr, inc, count, and it saturates at the maximum value.
- Everything else is a single always_ff next-state/PC block plus a small always_comb priority decode.

## Test plan
- **Reset and start:** Reset_n low mid-RUN with prog_ctr=0x123 → the next sample shows prog_ctr=0, IDLE, done=0, retired=0. Then start with start_addr=0x010 → prog_ctr=0x010, running=1.
- **Sequential run with stall:** five increments from 0x010, with stall held for 2 cycles in the middle → prog_ctr ends at 0x015 and retired=5. PC and retired are frozen during both stall cycles.
- **Branches from the LUT:**
  - pc=4, target=0xFFF → 3.
  - pc=2, target=0xFFB (-5) → 0xFFD.
  - pc=0x100, target=20 → 0x114.
  - target=0 → PC holds, and retired increments every cycle.
- **Wrap:** prog_ctr=0xFFF with no branch → 0x000, with no flag raised.
- **Halt priority:** halt, stall and branch_en all high at pc=0x030 → DONE, done=1, prog_ctr=0x030, retired+1. A start arriving in RUN the cycle before is ignored.
- **Restart and saturation:**
  - start in DONE with start_addr=0x200 → done=0, prog_ctr=0x200, retired=0.
  - With CW=4, 20 non-stalled instructions → retired=15.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Holds the default PC width, the run/halt state encoding and the modulo PC adder.
package pc_pkg;

  localparam int PC_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

  // Carry is dropped, so an all-ones offset behaves as -1.
  function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] pc,
                                             input logic [PC_W-1:0] off);
    return pc + off;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the core's decode stage and the PC sequencer.
// Handshake: start is a level request that is accepted on any edge where the
// sequencer is in IDLE or DONE and ignored in RUN; there is no ready/ack.
interface pc_sequencer_if
  import pc_pkg::*;
#(
  parameter int D  = PC_W,
  parameter int CW = 16
);
  logic          start;
  logic [D-1:0]  start_addr;
  logic          stall;
  logic          branch_en;
  logic [D-1:0]  target;
  logic          halt;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic [CW-1:0] retired;

  modport master (
    output start, start_addr, stall, branch_en, target, halt,
    input  prog_ctr, running, done, retired
  );

  modport slave (
    input  start, start_addr, stall, branch_en, target, halt,
    output prog_ctr, running, done, retired
  );
endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the retired count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increments, holds or branches the PC each cycle and
// owns the IDLE/RUN/DONE control of the core plus the retired-instruction count.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int D  = PC_W,
  parameter int CW = 16
) (
  input  logic           Clk,
  input  logic           Reset_n,
  pc_sequencer_if.slave  bus,
  output pc_state_t      o_dbg_state
);

  pc_state_t    r_state;
  logic [D-1:0] r_pc;
  logic         r_done;

  logic         w_accept;
  logic         w_halt;
  logic         w_step;
  logic         w_retire;
  logic [D-1:0] w_next_pc;

  // Halt outranks stall, stall outranks branch, branch outranks increment.
  always_comb begin
    w_accept  = bus.start && (r_state != RUN);
    w_halt    = (r_state == RUN) && bus.halt;
    w_step    = (r_state == RUN) && !bus.halt && !bus.stall;
    w_retire  = w_halt || w_step;
    w_next_pc = bus.branch_en ? pc_add(r_pc, bus.target) : pc_add(r_pc, D'(1));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_pc    <= bus.start_addr;
            r_done  <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (bus.halt) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (!bus.stall) begin
            r_pc <= w_next_pc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CW)) u_retired (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr     (w_accept),
    .inc     (w_retire),
    .count   (bus.retired)
  );

  assign bus.prog_ctr = r_pc;
  assign bus.running  = (r_state == RUN);
  assign bus.done     = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential run, branches, wrap,
// halt priority, restart, and counter saturation on a narrow-counter copy.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic clk;
  logic rst_n;
  pc_state_t dbg_state;
  pc_state_t dbg_state4;

  int n_pass;
  int n_total;

  pc_sequencer_if #(.D(12), .CW(16)) u_if ();
  pc_sequencer_if #(.D(12), .CW(4))  u_if4 ();

  pc_sequencer #(.D(12), .CW(16)) u_dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .bus         (u_if),
    .o_dbg_state (dbg_state)
  );

  pc_sequencer #(.D(12), .CW(4)) u_dut4 (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .bus         (u_if4),
    .o_dbg_state (dbg_state4)
  );

  assign u_if4.start      = u_if.start;
  assign u_if4.start_addr = u_if.start_addr;
  assign u_if4.stall      = u_if.stall;
  assign u_if4.branch_en  = u_if.branch_en;
  assign u_if4.target     = u_if.target;
  assign u_if4.halt       = u_if.halt;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [11:0] sa, input logic stl,
                       input logic br, input logic [11:0] tg, input logic hl);
    u_if.start      = st;
    u_if.start_addr = sa;
    u_if.stall      = stl;
    u_if.branch_en  = br;
    u_if.target     = tg;
    u_if.halt       = hl;
  endtask

  task automatic idle_in();
    drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0);
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [11:0] pc, input logic run,
                         input logic dn, input logic [15:0] ret);
    chk({tag, ".pc"},      32'(u_if.prog_ctr), 32'(pc));
    chk({tag, ".running"}, 32'(u_if.running),  32'(run));
    chk({tag, ".done"},    32'(u_if.done),     32'(dn));
    chk({tag, ".retired"}, 32'(u_if.retired),  32'(ret));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    idle_in();
    step();
    step();
    chk_all("reset", 12'h000, 1'b0, 1'b0, 16'd0);
    chk("reset.state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    step();

    // IDLE ignores everything except start
    drive(1'b0, 12'h000, 1'b0, 1'b1, 12'h055, 1'b1);
    step();
    chk_all("idle_ignore", 12'h000, 1'b0, 1'b0, 16'd0);

    // asynchronous reset in the middle of RUN
    drive(1'b1, 12'h123, 1'b0, 1'b0, 12'h000, 1'b0);
    step();
    idle_in();
    chk_all("run_123", 12'h123, 1'b1, 1'b0, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 12'h000, 1'b0, 1'b0, 16'd0);
    chk("async_rst.state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    step();

    // start at 0x010, then sequential run with a 2-cycle stall
    drive(1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 1'b0);
    step();
    idle_in();
    chk_all("start_010", 12'h010, 1'b1, 1'b0, 16'd0);
    chk("start_010.state", 32'(dbg_state), 32'(RUN));
    step();
    step();
    chk_all("seq_2", 12'h012, 1'b1, 1'b0, 16'd2);
    u_if.stall = 1'b1;
    step();
    chk_all("stall_1", 12'h012, 1'b1, 1'b0, 16'd2);
    step();
    chk_all("stall_2", 12'h012, 1'b1, 1'b0, 16'd2);
    u_if.stall = 1'b0;
    step();
    step();
    step();
    chk_all("seq_5", 12'h015, 1'b1, 1'b0, 16'd5);

    // branch -1 from 4
    u_if.halt = 1'b1;
    step();
    chk_all("halt_015", 12'h015, 1'b0, 1'b1, 16'd6);
    drive(1'b1, 12'h004, 1'b0, 1'b0, 12'h000, 1'b0);
    step();
    drive(1'b0, 12'h000, 1'b0, 1'b1, 12'hFFF, 1'b0);
    step();
    idle_in();
    chk_all("br_m1", 12'h003, 1'b1, 1'b0, 16'd1);

    // branch -5 from 2 underflows
    u_if.halt = 1'b1;
    step();
    drive(1'b1, 12'h002, 1'b0, 1'b0, 12'h000, 1'b0);
    step();
    drive(1'b0, 12'h000, 1'b0, 1'b1, 12'hFFB, 1'b0);
    step();
    idle_in();
    chk_all("br_m5", 12'hFFD, 1'b1, 1'b0, 16'd1);

    // increment wrap 0xFFF -> 0x000
    step();
    step();
    chk_all("pre_wrap", 12'hFFF, 1'b1, 1'b0, 16'd3);
    step();
    chk_all("wrap", 12'h000, 1'b1, 1'b0, 16'd4);

    // forward branch +20, then spin loop with target 0
    u_if.halt = 1'b1;
    step();
    drive(1'b1, 12'h100, 1'b0, 1'b0, 12'h000, 1'b0);
    step();
    drive(1'b0, 12'h000, 1'b0, 1'b1, 12'h014, 1'b0);
    step();
    chk_all("br_p20", 12'h114, 1'b1, 1'b0, 16'd1);
    u_if.target = 12'h000;
    step();
    chk_all("spin_1", 12'h114, 1'b1, 1'b0, 16'd2);
    step();
    chk_all("spin_2", 12'h114, 1'b1, 1'b0, 16'd3);

    // start ignored in RUN, then halt beats stall and branch
    drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1);
    step();
    drive(1'b1, 12'h02F, 1'b0, 1'b0, 12'h000, 1'b0);
    step();
    drive(1'b1, 12'h777, 1'b0, 1'b0, 12'h000, 1'b0);
    step();
    chk_all("start_in_run", 12'h030, 1'b1, 1'b0, 16'd1);
    drive(1'b0, 12'h000, 1'b1, 1'b1, 12'h005, 1'b1);
    step();
    idle_in();
    chk_all("halt_prio", 12'h030, 1'b0, 1'b1, 16'd2);
    chk("halt_prio.state", 32'(dbg_state), 32'(DONE));
    step();
    chk_all("done_hold", 12'h030, 1'b0, 1'b1, 16'd2);

    // restart from DONE, then saturate the 4-bit copy
    drive(1'b1, 12'h200, 1'b0, 1'b0, 12'h000, 1'b0);
    step();
    idle_in();
    chk_all("restart", 12'h200, 1'b1, 1'b0, 16'd0);
    chk("restart.ret4", 32'(u_if4.retired), 32'd0);
    for (int i = 0; i < 20; i++) step();
    chk_all("run20", 12'h214, 1'b1, 1'b0, 16'd20);
    chk("sat.ret4", 32'(u_if4.retired), 32'd15);
    chk("sat.pc4", 32'(u_if4.prog_ctr), 32'h214);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
